// File: rtl/halt_dump_unit_if.sv
// Signal bundle between the halt/dump engine and its surroundings:
// the CPU (instrW in, halt out), the data RAM read port and the dump stream.
//
// Dump stream handshake: a word transfers on a rising edge where
// dump_valid=1 and dump_ready=1. Once dump_valid rises it stays high, and
// dump_data/dump_index/dump_last stay unchanged, until that transfer happens.
// dump_valid never depends combinationally on dump_ready.
interface halt_dump_unit_if #(
    parameter int AW = 9,
    parameter int DW = 32
);
    logic [DW-1:0] instrW;
    logic          halt;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          dump_valid;
    logic          dump_ready;
    logic [DW-1:0] dump_data;
    logic [AW-1:0] dump_index;
    logic          dump_last;
    logic          done;

    // The dump engine side.
    modport master (
        input  instrW,
        input  mem_rdata,
        input  dump_ready,
        output halt,
        output mem_re,
        output mem_addr,
        output dump_valid,
        output dump_data,
        output dump_index,
        output dump_last,
        output done
    );

    // The CPU / RAM / consumer side.
    modport slave (
        output instrW,
        output mem_rdata,
        output dump_ready,
        input  halt,
        input  mem_re,
        input  mem_addr,
        input  dump_valid,
        input  dump_data,
        input  dump_index,
        input  dump_last,
        input  done
    );
endinterface

// File: rtl/halt_dump_unit.sv
// End-of-program dump engine. Watches the writeback instruction for the halt
// word, freezes the core, then walks data memory from address 0 to DEPTH-1,
// presenting each word on the dump stream, and finally raises done.
// One word costs ISSUE (RAM read), LATCH (RAM data returns and is captured)
// and SEND (offer to consumer until accepted).
module halt_dump_unit #(
    parameter int            DEPTH      = 512,
    parameter int            AW         = 9,
    parameter int            DW         = 32,
    parameter logic [DW-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
    input  logic                CLK,
    input  logic                reset,
    halt_dump_unit_if.master    bus,
    output logic [2:0]          dbg_state
);

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        ISSUE = 3'd1,
        LATCH = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Terminal address compare is against DEPTH-1 so non-power-of-two
    // depths stop at the right word instead of running to 2^AW-1.
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] ptr;
    logic [AW-1:0] ptr_nxt;
    logic [DW-1:0] data_q;
    logic          capture;

    // State, address pointer and captured RAM word; reset wins over all.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state  <= RUN;
            ptr    <= '0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (capture) begin
                data_q <= bus.mem_rdata;
            end
        end
    end

    // Next-state, pointer update and all outputs, decoded from current state.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        capture        = 1'b0;
        bus.halt       = 1'b1;
        bus.mem_re     = 1'b0;
        bus.mem_addr   = ptr;
        bus.dump_valid = 1'b0;
        bus.dump_data  = data_q;
        bus.dump_index = ptr;
        bus.dump_last  = 1'b0;
        bus.done       = 1'b0;

        case (state)
            RUN: begin
                bus.halt = 1'b0;
                if (bus.instrW == HALT_INSTR) begin
                    state_nxt = ISSUE;
                    ptr_nxt   = '0;
                end
            end
            ISSUE: begin
                bus.mem_re = 1'b1;
                state_nxt  = LATCH;
            end
            LATCH: begin
                // Synchronous RAM: data for the ISSUE read is on mem_rdata now.
                capture   = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                bus.dump_valid = 1'b1;
                bus.dump_last  = (ptr == LAST_ADDR);
                if (bus.dump_ready) begin
                    if (ptr == LAST_ADDR) begin
                        state_nxt = DONE;
                    end else begin
                        ptr_nxt   = ptr + AW'(1);
                        state_nxt = ISSUE;
                    end
                end
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    assign dbg_state = state;

    // A stalled word must not change under the consumer.
    a_stall_stable: assert property (@(posedge CLK)
        (!reset && bus.dump_valid && !bus.dump_ready) |=>
        (bus.dump_valid && $stable(bus.dump_data) &&
         $stable(bus.dump_index) && $stable(bus.dump_last)));

    // RAM is only read while the core is frozen.
    a_read_halted: assert property (@(posedge CLK) bus.mem_re |-> bus.halt);

    // Nothing moves once the dump has completed.
    a_done_quiet: assert property (@(posedge CLK)
        bus.done |-> (!bus.dump_valid && !bus.mem_re && bus.halt));

endmodule
